// File: rtl/wb_keyboard.sv
// PS/2 keyboard receiver feeding a scancode FIFO, read and flushed through a Wishbone slave port.
// Optional feature macro: WB_KEYBOARD_PARITY_CHECK_EN (drop frames with bad odd parity and flag them).
`timescale 1ns/1ps
module wb_keyboard #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  input  logic        ps2_clk,
  input  logic        ps2_data
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } RxState;

  RxState r_state;
  RxState w_nextState;

  logic [1:0]    r_ps2ClkSync;
  logic [1:0]    r_ps2DataSync;
  logic          r_ps2ClkPrev;
  logic [2:0]    r_bitCnt;
  logic [7:0]    r_shift;
  logic [TW-1:0] r_toCnt;

  logic          r_ack;
  logic [31:0]   r_datO;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_parErr;

  logic w_ps2Fall;
  logic w_ps2Bit;
  logic w_timeout;
  logic w_frameDone;
  logic w_parityOk;
  logic w_parErrSet;
  logic w_push;
  logic w_doPush;
  logic w_txn;
  logic w_pop;
  logic w_flush;
  logic w_empty;
  logic w_full;
  logic w_unused;

  // Only DAT_I[0] carries meaning; the rest is folded away.
  assign w_unused = ^DAT_I[31:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ps2ClkSync  <= 2'b11;
      r_ps2DataSync <= 2'b11;
      r_ps2ClkPrev  <= 1'b1;
    end else begin
      r_ps2ClkSync  <= {r_ps2ClkSync[0], ps2_clk};
      r_ps2DataSync <= {r_ps2DataSync[0], ps2_data};
      r_ps2ClkPrev  <= r_ps2ClkSync[1];
    end
  end

  assign w_ps2Fall = r_ps2ClkPrev & ~r_ps2ClkSync[1];
  assign w_ps2Bit  = r_ps2DataSync[1];
  assign w_timeout = (r_state != IDLE) && !w_ps2Fall &&
                     (r_toCnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_frameDone = 1'b0;
    if (w_timeout) begin
      w_nextState = IDLE;
    end else if (w_ps2Fall) begin
      case (r_state)
        IDLE:    if (!w_ps2Bit) w_nextState = DATA;
        DATA:    if (r_bitCnt == 3'd7) w_nextState = PARITY;
        PARITY:  w_nextState = STOP;
        STOP: begin
          w_frameDone = w_ps2Bit;
          w_nextState = IDLE;
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

`ifdef WB_KEYBOARD_PARITY_CHECK_EN
  logic r_parity;

  // Odd parity: data plus parity bit must contain an odd number of ones.
  assign w_parityOk  = ^{r_shift, r_parity};
  assign w_parErrSet = w_frameDone & ~w_parityOk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_ps2Fall && r_state == PARITY) begin
      r_parity <= w_ps2Bit;
    end
  end
`else
  assign w_parityOk  = 1'b1;
  assign w_parErrSet = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_toCnt  <= '0;
    end else begin
      if (r_state == IDLE || w_ps2Fall) begin
        r_toCnt <= '0;
      end else begin
        r_toCnt <= r_toCnt + TW'(1);
      end
      if (w_ps2Fall) begin
        case (r_state)
          IDLE: r_bitCnt <= '0;
          DATA: begin
            r_shift  <= {w_ps2Bit, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_txn    = STB & ~r_ack;
  assign w_pop    = w_txn & ~WE & ~w_empty;
  assign w_flush  = w_txn & WE & DAT_I[0];
  assign w_push   = w_frameDone & w_parityOk;
  assign w_doPush = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_doPush && !w_flush) begin
      r_mem[r_wrPtr] <= r_shift;
    end
  end

  // Status is captured before this edge's push/pop/flush takes effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack      <= 1'b0;
      r_datO     <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_parErr   <= 1'b0;
    end else begin
      r_ack <= w_txn;
      if (w_txn) begin
        r_datO <= {21'b0, r_parErr, r_overflow, ~w_empty,
                   w_empty ? 8'h00 : r_mem[r_rdPtr]};
      end
      if (w_flush) begin
        r_wrPtr    <= '0;
        r_rdPtr    <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
        r_parErr   <= 1'b0;
      end else begin
        if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
        if (w_pop)    r_rdPtr <= r_rdPtr + AW'(1);
        r_count <= r_count + CW'(w_doPush) - CW'(w_pop);
        if (w_push && !w_doPush) r_overflow <= 1'b1;
        if (w_parErrSet)         r_parErr   <= 1'b1;
      end
    end
  end

  assign ACK   = r_ack;
  assign DAT_O = r_datO;

endmodule
